msrv32_alu_arbiter: RTL and testbench

// - Shares one msrv32 ALU between two requesters (req0: integer pipe, req1: address/CSR helper).
// - Arbitrates, registers operands into the ALU, captures the result and returns it on one

---
 rtl/msrv32_alu_arbiter.sv | 143 ++++++++++++++
 tb/tb_msrv32_alu_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_alu_arbiter.sv
// msrv32_alu_arbiter: shares one combinational ALU between two requesters
// (req0 integer pipe, req1 address/CSR helper) and returns tagged results.
//
// Ports:
//   ms_riscv32_mp_clk_in / ms_riscv32_mp_rst_in : clock, async active-high reset
//   reqN_valid_in, reqN_ready_out               : request handshake, N = 0/1
//   reqN_op1_in, reqN_op2_in, reqN_opcode_in    : request operands and opcode
//   alu_op_1_out, alu_op_2_out, alu_opcode_out  : registered ALU inputs
//   alu_result_in                               : ALU combinational result
//   rsp_valid_out, rsp_ready_in                 : response handshake
//   rsp_id_out, rsp_result_out                  : responder id and result
//
// Build option: ALU_ARB_RR_EN selects round-robin arbitration; without it
// req0 has fixed priority and req1 is forced after MAX_WAIT req0 grants.

module msrv32_alu_arbiter #(
    parameter int DATA_W   = 32,
    parameter int OPC_W    = 4,
    parameter int MAX_WAIT = 4
) (
    input  logic              ms_riscv32_mp_clk_in,
    input  logic              ms_riscv32_mp_rst_in,
    input  logic              req0_valid_in,
    output logic              req0_ready_out,
    input  logic [DATA_W-1:0] req0_op1_in,
    input  logic [DATA_W-1:0] req0_op2_in,
    input  logic [OPC_W-1:0]  req0_opcode_in,
    input  logic              req1_valid_in,
    output logic              req1_ready_out,
    input  logic [DATA_W-1:0] req1_op1_in,
    input  logic [DATA_W-1:0] req1_op2_in,
    input  logic [OPC_W-1:0]  req1_opcode_in,
    output logic [DATA_W-1:0] alu_op_1_out,
    output logic [DATA_W-1:0] alu_op_2_out,
    output logic [OPC_W-1:0]  alu_opcode_out,
    input  logic [DATA_W-1:0] alu_result_in,
    output logic              rsp_valid_out,
    output logic              rsp_id_out,
    output logic [DATA_W-1:0] rsp_result_out,
    input  logic              rsp_ready_in
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t state;
    logic   id_q;
    logic   window;
    logic   gnt1;
    logic   xfer0;
    logic   xfer1;
    logic   xfer;

`ifdef ALU_ARB_RR_EN
    // 1 = req1 wins the next simultaneous request
    logic   rr_ptr;
`else
    localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);
    logic [CNT_W-1:0] wait_cnt;
`endif

    always_comb begin
        // Reset gates the grant window so ready outputs are 0 during reset
        window = !ms_riscv32_mp_rst_in &&
                 ((state == IDLE) || ((state == RESP) && rsp_ready_in));
`ifdef ALU_ARB_RR_EN
        gnt1 = req1_valid_in && (!req0_valid_in || rr_ptr);
`else
        gnt1 = req1_valid_in && (!req0_valid_in || (wait_cnt == CNT_MAX));
`endif
        req0_ready_out = window && req0_valid_in && !gnt1;
        req1_ready_out = window && gnt1;
        xfer0 = req0_ready_out;
        xfer1 = req1_ready_out;
        xfer  = xfer0 || xfer1;
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state          <= IDLE;
            id_q           <= 1'b0;
            alu_op_1_out   <= '0;
            alu_op_2_out   <= '0;
            alu_opcode_out <= '0;
            rsp_valid_out  <= 1'b0;
            rsp_id_out     <= 1'b0;
            rsp_result_out <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (xfer) state <= EXEC;
                end
                EXEC: begin
                    rsp_result_out <= alu_result_in;
                    rsp_id_out     <= id_q;
                    rsp_valid_out  <= 1'b1;
                    state          <= RESP;
                end
                RESP: begin
                    if (rsp_ready_in) begin
                        rsp_valid_out <= 1'b0;
                        state         <= xfer ? EXEC : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Operands only load on a transfer so the ALU inputs hold when idle
            if (xfer) begin
                id_q           <= xfer1;
                alu_op_1_out   <= xfer1 ? req1_op1_in    : req0_op1_in;
                alu_op_2_out   <= xfer1 ? req1_op2_in    : req0_op2_in;
                alu_opcode_out <= xfer1 ? req1_opcode_in : req0_opcode_in;
            end
        end
    end

`ifdef ALU_ARB_RR_EN
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            rr_ptr <= 1'b0;
        end else if (xfer) begin
            rr_ptr <= !xfer1;
        end
    end
`else
    // Counts req0 wins while req1 is kept waiting
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            wait_cnt <= '0;
        end else if (!req1_valid_in || xfer1) begin
            wait_cnt <= '0;
        end else if (xfer0 && (wait_cnt != CNT_MAX)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_msrv32_alu_arbiter.sv
// Bench for msrv32_alu_arbiter: scoreboard of tagged results, handshake
// timing, backpressure, contention ordering and asynchronous reset.

module tb_msrv32_alu_arbiter;

    localparam int DW = 32;
    localparam int OW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0;
    logic          req0_ready;
    logic [DW-1:0] req0_op1 = '0;
    logic [DW-1:0] req0_op2 = '0;
    logic [OW-1:0] req0_opc = '0;
    logic          req1_valid = 1'b0;
    logic          req1_ready;
    logic [DW-1:0] req1_op1 = '0;
    logic [DW-1:0] req1_op2 = '0;
    logic [OW-1:0] req1_opc = '0;
    logic [DW-1:0] alu_op_1;
    logic [DW-1:0] alu_op_2;
    logic [OW-1:0] alu_opc;
    logic [DW-1:0] alu_result;
    logic          rsp_valid;
    logic          rsp_id;
    logic [DW-1:0] rsp_result;
    logic          rsp_ready = 1'b0;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    logic [DW:0] sb[$];
    bit          xlog[$];

    msrv32_alu_arbiter #(.DATA_W(DW), .OPC_W(OW), .MAX_WAIT(4)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .req0_valid_in        (req0_valid),
        .req0_ready_out       (req0_ready),
        .req0_op1_in          (req0_op1),
        .req0_op2_in          (req0_op2),
        .req0_opcode_in       (req0_opc),
        .req1_valid_in        (req1_valid),
        .req1_ready_out       (req1_ready),
        .req1_op1_in          (req1_op1),
        .req1_op2_in          (req1_op2),
        .req1_opcode_in       (req1_opc),
        .alu_op_1_out         (alu_op_1),
        .alu_op_2_out         (alu_op_2),
        .alu_opcode_out       (alu_opc),
        .alu_result_in        (alu_result),
        .rsp_valid_out        (rsp_valid),
        .rsp_id_out           (rsp_id),
        .rsp_result_out       (rsp_result),
        .rsp_ready_in         (rsp_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a,
                                            input logic [DW-1:0] b,
                                            input logic [OW-1:0] op);
        logic [DW-1:0] r;
        r = '0;
        case (op[2:0])
            3'b000: r = op[3] ? a - b : a + b;
            3'b001: r = a << b[4:0];
            3'b010: r = {31'd0, $signed(a) < $signed(b)};
            3'b011: r = {31'd0, a < b};
            3'b100: r = a ^ b;
            3'b101: r = op[3] ? DW'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'b110: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    // The shared combinational ALU the arbiter feeds
    always_comb alu_result = alu_f(alu_op_1, alu_op_2, alu_opc);

    // Scoreboard: push on request handshake, pop on response handshake
    always @(negedge clk) begin
        logic [DW:0] e;
        if (!rst) begin
            if (rsp_valid && rsp_ready) begin
                total++;
                if (sb.size() == 0) begin
                    $display("FAIL rsp_unexpected got id=%0d res=%h want none",
                             rsp_id, rsp_result);
                end else begin
                    e = sb.pop_front();
                    if ({rsp_id, rsp_result} !== e)
                        $display("FAIL rsp_data got id=%0d res=%h want id=%0d res=%h",
                                 rsp_id, rsp_result, e[DW], e[DW-1:0]);
                    else
                        passed++;
                end
            end
            if (req0_valid && req0_ready) begin
                sb.push_back({1'b0, alu_f(req0_op1, req0_op2, req0_opc)});
                xlog.push_back(1'b0);
            end
            if (req1_valid && req1_ready) begin
                sb.push_back({1'b1, alu_f(req1_op1, req1_op2, req1_opc)});
                xlog.push_back(1'b1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            step();
            n++;
        end
        total++;
        if (sb.size() != 0)
            $display("FAIL drain got %0d pending want 0", sb.size());
        else
            passed++;
    endtask

    task automatic issue(input bit id, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [OW-1:0] op);
        int n = 0;
        if (id) begin
            req1_valid = 1; req1_op1 = a; req1_op2 = b; req1_opc = op;
        end else begin
            req0_valid = 1; req0_op1 = a; req0_op2 = b; req0_opc = op;
        end
        #1;
        while (!(id ? req1_ready : req0_ready) && n < 20) begin
            step();
            n++;
        end
        total++;
        if (n >= 20) $display("FAIL issue_timeout req%0d got no ready", id);
        else passed++;
        step();
        req0_valid = 0;
        req1_valid = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        step();
        step();
        rst = 0;
        sb.delete();
        xlog.delete();
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1;
        #1;
        total++;
        if ({req0_ready, req1_ready, rsp_valid, rsp_id} !== 4'b0 ||
            alu_op_1 !== '0 || alu_op_2 !== '0 || alu_opc !== '0 ||
            rsp_result !== '0)
            $display("FAIL reset_outputs got rv=%b res=%h op1=%h want all 0",
                     rsp_valid, rsp_result, alu_op_1);
        else
            passed++;
        step();
        rst = 0;
        step();
    endtask

    task automatic test_single();
        rsp_ready = 1;
        req0_valid = 1; req0_op1 = 5; req0_op2 = 3; req0_opc = 4'b0000;
        #1;
        total++;
        if (req0_ready !== 1'b1) $display("FAIL single_ready got %b want 1", req0_ready);
        else passed++;
        step();
        req0_valid = 0;
        total++;
        if (rsp_valid !== 1'b0 || alu_op_1 !== 32'd5 || alu_op_2 !== 32'd3 || alu_opc !== 4'd0)
            $display("FAIL single_exec got rv=%b op1=%h op2=%h opc=%h want 0/5/3/0",
                     rsp_valid, alu_op_1, alu_op_2, alu_opc);
        else
            passed++;
        step();
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd8)
            $display("FAIL single_rsp got rv=%b id=%b res=%h want 1/0/8",
                     rsp_valid, rsp_id, rsp_result);
        else
            passed++;
        step();
        step();
        total++;
        if (rsp_valid !== 1'b0 || alu_op_1 !== 32'd5)
            $display("FAIL single_hold got rv=%b op1=%h want 0/5", rsp_valid, alu_op_1);
        else
            passed++;
        drain();
    endtask

    task automatic test_sub_sra();
        rsp_ready = 1;
        issue(1'b1, 32'h8000_0000, 32'd4, 4'b1101);
        step();
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 32'hF800_0000)
            $display("FAIL sra_rsp got rv=%b id=%b res=%h want 1/1/f8000000",
                     rsp_valid, rsp_id, rsp_result);
        else
            passed++;
        issue(1'b0, 32'd3, 32'd10, 4'b1000);
        drain();
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] ea;
        logic [DW-1:0] eb;
        ea = alu_f(32'h0000_00F0, 32'h0000_0F0F, 4'b0100);
        eb = alu_f(32'd1, 32'd31, 4'b0001);
        rsp_ready = 0;
        issue(1'b0, 32'h0000_00F0, 32'h0000_0F0F, 4'b0100);
        step();
        req0_valid = 1; req0_op1 = 32'd1; req0_op2 = 32'd31; req0_opc = 4'b0001;
        #1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (req0_ready !== 1'b0 || rsp_valid !== 1'b1 ||
                rsp_id !== 1'b0 || rsp_result !== ea)
                $display("FAIL bp_hold%0d got rdy=%b rv=%b res=%h want 0/1/%h",
                         i, req0_ready, rsp_valid, rsp_result, ea);
            else
                passed++;
            step();
        end
        rsp_ready = 1;
        #1;
        total++;
        if (req0_ready !== 1'b1) $display("FAIL bp_release got %b want 1", req0_ready);
        else passed++;
        step();
        req0_valid = 0;
        step();
        total++;
        if (rsp_valid !== 1'b1 || rsp_result !== eb)
            $display("FAIL bp_next got rv=%b res=%h want 1/%h", rsp_valid, rsp_result, eb);
        else
            passed++;
        drain();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] a[4] = '{32'hFFFF_FFFF, 32'd7, 32'h1234_5678, 32'hA5A5_A5A5};
        logic [DW-1:0] b[4] = '{32'd1, 32'd9, 32'h0F0F_0F0F, 32'h0000_FFFF};
        logic [OW-1:0] o[4] = '{4'b0010, 4'b0011, 4'b0110, 4'b0111};
        int last = 0;
        int n;
        rsp_ready = 1;
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1; req0_op1 = a[i]; req0_op2 = b[i]; req0_opc = o[i];
            #1;
            n = 0;
            while (!req0_ready && n < 20) begin
                step();
                n++;
            end
            if (i > 0) begin
                total++;
                if (cyc - last !== 2)
                    $display("FAIL b2b_gap%0d got %0d want 2", i, cyc - last);
                else
                    passed++;
            end
            last = cyc;
            step();
        end
        req0_valid = 0;
        drain();
    endtask

    task automatic test_mid_reset();
        rsp_ready = 1;
        req0_valid = 1; req0_op1 = 32'h1234; req0_op2 = 32'h55; req0_opc = 4'b0110;
        #1;
        step();
        req1_valid = 1; req1_op1 = 32'd9; req1_op2 = 32'd9; req1_opc = 4'b0000;
        rst = 1;
        #1;
        sb.delete();
        total++;
        if ({req0_ready, req1_ready, rsp_valid, rsp_id} !== 4'b0 ||
            alu_op_1 !== '0 || alu_op_2 !== '0 || alu_opc !== '0 ||
            rsp_result !== '0)
            $display("FAIL midreset_outputs got rv=%b op1=%h rdy=%b%b want all 0",
                     rsp_valid, alu_op_1, req0_ready, req1_ready);
        else
            passed++;
        step();
        rst = 0;
        #1;
        total++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
            $display("FAIL midreset_grant got r0=%b r1=%b want 1/0", req0_ready, req1_ready);
        else
            passed++;
        step();
        req0_valid = 0;
        req1_valid = 0;
        drain();
    endtask

    task automatic test_contention();
`ifdef ALU_ARB_RR_EN
        localparam int N = 6;
        bit exp_ids[N] = '{0, 1, 0, 1, 0, 1};
`else
        localparam int N = 10;
        bit exp_ids[N] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif
        int n = 0;
        do_reset();
        rsp_ready = 1;
        req0_valid = 1; req0_op1 = 32'd100; req0_op2 = 32'd1; req0_opc = 4'b0000;
        req1_valid = 1; req1_op1 = 32'd100; req1_op2 = 32'd1; req1_opc = 4'b1000;
        while (xlog.size() < N && n < 200) begin
            step();
            n++;
        end
        req0_valid = 0;
        req1_valid = 0;
        total++;
        if (xlog.size() != N) $display("FAIL cont_count got %0d want %0d", xlog.size(), N);
        else passed++;
        for (int i = 0; i < N && i < xlog.size(); i++) begin
            total++;
            if (xlog[i] !== exp_ids[i])
                $display("FAIL cont_id%0d got %0d want %0d", i, xlog[i], exp_ids[i]);
            else
                passed++;
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_sub_sra();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        test_contention();
        repeat (3) step();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
